encoder8to3_queue: RTL and testbench
====================================

# encoder8to3_queue

Sequential 8-to-3 priority encoder with request buffering. It is the return path for the 3-to-8 one-hot decode: eight request lines Y0..Y7 are captured into a pending register, and each pending request is presented in turn as a 3-bit code W2..W0 under a VALID/ACK handshake. Highest index has priority. A served request is cleared only when it is acknowledged.

## Interface
Parameters:
- none (width fixed at 8 requests / 3-bit code)

Ports:
- Clock  input  1  single clock; all state changes on the rising edge
- Reset  input  1  asynchronous, active-high reset
- EN  input  1  request-capture enable; when 0, Y0..Y7 are ignored
- Y0..Y7  input  1 each  request lines; Yk=1 requests code k
- ACK  input  1  consumer accepts the presented code
- W2, W1, W0  output  1 each  encoded index of the granted request, W2 = MSB
- VALID  output  1  W2..W0 holds a granted request
- OVF  output  1  one-cycle pulse: a request was dropped into an already-pending bit
- EMPTY  output  1  no pending request and VALID=0 (combinational from registers)

## Operation
- Internal state:
  - 8-bit pending register P[7:0].
  - 1-bit FSM with states IDLE and PRESENT.
  - Registered W[2:0], VALID and OVF.
- Capture: at each edge, if EN=1, set P[k] for every Yk=1. Capture is independent of FSM state.
- Clear: in PRESENT with ACK=1, clear P[W]. If Y[W]=1 with EN=1 in the same cycle, set wins and P[W] stays 1 (new request retained).
- FSM:
  - IDLE: if P≠0, load W with the index of the highest set bit of P (P7 highest), set VALID=1 and go to PRESENT. Otherwise remain in IDLE with VALID=0.
  - PRESENT: W and VALID hold stable until ACK=1. On ACK, VALID←0 and go to IDLE. A new higher-priority request does not preempt the presented code.
  - ACK in IDLE is ignored.
- OVF: set to 1 for one cycle when EN=1, Yk=1 and P[k]=1 already, for any k, unless bit k is being cleared by ACK in that cycle. Otherwise OVF=0. The duplicate request merges into the existing pending bit; no count is kept.
- EN=0 does not stall the handshake. Pending requests continue to be served.
- Arithmetic: encode only, with no carry or wrap. W is always a value from 0 to 7 that indexes a set P bit at load time.

## Timing
- Reset (asynchronous, any time): P=0, state=IDLE, W=000, VALID=0, OVF=0, EMPTY=1. Any in-flight grant is aborted and pending requests are lost. Normal operation resumes on the first edge after Reset deasserts.
- Request latency: Yk sampled at edge N sets P[k] after N. VALID rises after edge N+1 with W=k, provided the FSM was in IDLE and k is the highest pending bit.
- Grant turnaround: ACK sampled at edge M drops VALID after M. The next grant can appear after edge M+1 at the earliest, so there is always one idle cycle between grants.
- Sustained throughput: one grant per 2 cycles with ACK held high.
- OVF is registered and is asserted during the cycle after the offending edge.
- EMPTY reflects the register state after each edge. It has no extra latency.

## Test plan
- Reset then single request: pulse Y5 with EN=1 for 1 cycle, hold ACK=0. Required: W=101 and VALID=1 from the 2nd edge, held stable; EMPTY=0. Raise ACK. Required: VALID=0 after that edge, and EMPTY=1 one cycle later.
- Priority and no preemption: present Y1 and Y3 together. Required: grant W=011. While it is presented, assert Y7. Required: W stays 011 until ACK. Following grants are W=111, then W=001, with one idle cycle between each.
- EN gating: hold EN=0 with Y0..Y7=FF for 4 cycles. Required: VALID=0, EMPTY=1, OVF=0 throughout.
- Overflow and set-wins: with Y2 pending and not presented, pulse Y2 again. Required: OVF=1 for one cycle. Then, with W=010 presented, assert ACK and Y2 in the same cycle. Required: OVF=0, and W=010 is granted again after the idle cycle.
- Async reset mid-grant: with VALID=1, W=110 and P=0x48, pulse Reset between clock edges. Required: VALID=0, W=000, OVF=0 and EMPTY=1 immediately, with no grant afterwards until new requests arrive.

Source files
------------

// File: rtl/encoder8to3_queue.sv
// Sequential 8-to-3 priority encoder: buffers request lines in a pending register
// and presents the highest pending index under a VALID/ACK handshake.
module encoder8to3_queue (
    input  logic Clock,
    input  logic Reset,
    input  logic EN,
    input  logic Y0,
    input  logic Y1,
    input  logic Y2,
    input  logic Y3,
    input  logic Y4,
    input  logic Y5,
    input  logic Y6,
    input  logic Y7,
    input  logic ACK,
    output logic W2,
    output logic W1,
    output logic W0,
    output logic VALID,
    output logic OVF,
    output logic EMPTY
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e      state_q, state_d;
    logic [7:0]  pend_q, pend_d;
    logic [2:0]  w_q, w_d;
    logic        valid_q, valid_d;
    logic        ovf_q, ovf_d;

    logic [7:0]  req;
    logic [7:0]  cap;
    logic [7:0]  clr;
    logic [2:0]  top_idx;

    assign req = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};
    assign cap = EN ? req : 8'h00;
    assign clr = (state_q == StPresent && ACK) ? (8'h01 << w_q) : 8'h00;

    // Ascending scan so the highest set bit is the one that sticks.
    always_comb begin
        top_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pend_q[i]) top_idx = 3'(i);
        end
    end

    always_comb begin
        // Set wins over clear when a served bit is re-requested on its ACK cycle.
        pend_d  = (pend_q & ~clr) | cap;
        ovf_d   = |(cap & pend_q & ~clr);
        state_d = state_q;
        w_d     = w_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (pend_q != 8'h00) begin
                    w_d     = top_idx;
                    valid_d = 1'b1;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (ACK) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            pend_q  <= 8'h00;
            w_q     <= 3'd0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            w_q     <= w_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign {W2, W1, W0} = w_q;
    assign VALID        = valid_q;
    assign OVF          = ovf_q;
    assign EMPTY        = (pend_q == 8'h00) && !valid_q;

endmodule

// File: tb/tb_encoder8to3_queue.sv
// Directed bench for encoder8to3_queue with hand-computed expectations.
module tb_encoder8to3_queue;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       EN;
    logic       ACK;
    logic [7:0] y;
    logic       W2, W1, W0, VALID, OVF, EMPTY;
    logic [2:0] code;

    int checks = 0;
    int errors = 0;

    assign code = {W2, W1, W0};

    always #5 Clock = ~Clock;

    encoder8to3_queue dut (
        .Clock (Clock),
        .Reset (Reset),
        .EN    (EN),
        .Y0    (y[0]),
        .Y1    (y[1]),
        .Y2    (y[2]),
        .Y3    (y[3]),
        .Y4    (y[4]),
        .Y5    (y[5]),
        .Y6    (y[6]),
        .Y7    (y[7]),
        .ACK   (ACK),
        .W2    (W2),
        .W1    (W1),
        .W0    (W0),
        .VALID (VALID),
        .OVF   (OVF),
        .EMPTY (EMPTY)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        EN    = 1'b0;
        ACK   = 1'b0;
        y     = 8'h00;
        #2;
        check("rst_valid", 8'(VALID), 8'd0);
        check("rst_code",  8'(code),  8'd0);
        check("rst_ovf",   8'(OVF),   8'd0);
        check("rst_empty", 8'(EMPTY), 8'd1);
        #10 Reset = 1'b0;
        tick();

        // Single request
        y = 8'h20; EN = 1'b1;
        tick(); y = 8'h00;
        check("t1_valid_edge1", 8'(VALID), 8'd0);
        check("t1_empty_edge1", 8'(EMPTY), 8'd0);
        tick();
        check("t1_valid_edge2", 8'(VALID), 8'd1);
        check("t1_code_edge2",  8'(code),  8'd5);
        tick();
        check("t1_valid_hold",  8'(VALID), 8'd1);
        check("t1_code_hold",   8'(code),  8'd5);
        check("t1_empty_hold",  8'(EMPTY), 8'd0);
        ACK = 1'b1;
        tick(); ACK = 1'b0;
        check("t1_valid_ack",   8'(VALID), 8'd0);
        tick();
        check("t1_empty_after", 8'(EMPTY), 8'd1);
        check("t1_no_regrant",  8'(VALID), 8'd0);

        // Priority and no preemption
        y = 8'h0A;
        tick(); y = 8'h00;
        tick();
        check("t2_valid3", 8'(VALID), 8'd1);
        check("t2_code3",  8'(code),  8'd3);
        y = 8'h80;
        tick(); y = 8'h00;
        check("t2_code3_keep", 8'(code), 8'd3);
        check("t2_ovf0",       8'(OVF),  8'd0);
        tick();
        check("t2_code3_keep2", 8'(code), 8'd3);
        ACK = 1'b1;
        tick(); ACK = 1'b0;
        check("t2_idle1", 8'(VALID), 8'd0);
        tick();
        check("t2_valid7", 8'(VALID), 8'd1);
        check("t2_code7",  8'(code),  8'd7);
        ACK = 1'b1;
        tick(); ACK = 1'b0;
        check("t2_idle2", 8'(VALID), 8'd0);
        tick();
        check("t2_valid1", 8'(VALID), 8'd1);
        check("t2_code1",  8'(code),  8'd1);
        ACK = 1'b1;
        tick(); ACK = 1'b0;
        tick();
        check("t2_empty", 8'(EMPTY), 8'd1);

        // EN gating
        EN = 1'b0; y = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_valid", 8'(VALID), 8'd0);
            check("t3_empty", 8'(EMPTY), 8'd1);
            check("t3_ovf",   8'(OVF),   8'd0);
        end
        y = 8'h00; EN = 1'b1;

        // Overflow and set-wins
        y = 8'h44;
        tick(); y = 8'h00;
        tick();
        check("t4_code6", 8'(code), 8'd6);
        y = 8'h04;
        tick(); y = 8'h00;
        check("t4_ovf1", 8'(OVF), 8'd1);
        tick();
        check("t4_ovf_pulse", 8'(OVF), 8'd0);
        ACK = 1'b1;
        tick(); ACK = 1'b0;
        tick();
        check("t4_valid2", 8'(VALID), 8'd1);
        check("t4_code2",  8'(code),  8'd2);
        ACK = 1'b1; y = 8'h04;
        tick(); ACK = 1'b0; y = 8'h00;
        check("t4_ovf_setwins", 8'(OVF),   8'd0);
        check("t4_valid_gap",   8'(VALID), 8'd0);
        check("t4_pending",     8'(EMPTY), 8'd0);
        tick();
        check("t4_regrant_valid", 8'(VALID), 8'd1);
        check("t4_regrant_code",  8'(code),  8'd2);
        ACK = 1'b1;
        tick(); ACK = 1'b0;
        tick();
        check("t4_empty", 8'(EMPTY), 8'd1);

        // Async reset mid-grant
        y = 8'h48;
        tick(); y = 8'h00;
        tick();
        check("t5_valid6", 8'(VALID), 8'd1);
        check("t5_code6",  8'(code),  8'd6);
        #3 Reset = 1'b1;
        #1;
        check("t5_rst_valid", 8'(VALID), 8'd0);
        check("t5_rst_code",  8'(code),  8'd0);
        check("t5_rst_ovf",   8'(OVF),   8'd0);
        check("t5_rst_empty", 8'(EMPTY), 8'd1);
        #1 Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_grant", 8'(VALID), 8'd0);
            check("t5_empty",    8'(EMPTY), 8'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
